// File: rtl/cpu_debug_jtag_host_pkg.sv
// Shared types and constants for the CPU debug JTAG host.
package cpu_debug_jtag_pkg;

    localparam int DEF_DR_WIDTH = 38;
    localparam int DEF_IR_WIDTH = 2;
    localparam int DEF_TCK_DIV  = 2;

    localparam logic [DEF_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [DEF_IR_WIDTH-1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [DEF_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
    localparam logic [DEF_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RESP
    } state_t;

endpackage

// File: rtl/cpu_debug_jtag_host_if.sv
// Command/response handshake between a debug command source and the JTAG host.
interface cpu_debug_jtag_host_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    // Command source side.
    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );

    // JTAG host side.
    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );
endinterface

// File: rtl/cpu_debug_jtag_tck_gen.sv
// TCK divider: one period is 2*TCK_DIV clk cycles, low half first.
// o_rise marks the last low cycle (TCK rises at its end), o_fall the last high cycle.
module cpu_debug_jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise,
    output logic o_fall
);
    localparam int            CW         = $clog2(2 * TCK_DIV) + 1;
    localparam logic [CW-1:0] LAST_LOW   = CW'(TCK_DIV - 1);
    localparam logic [CW-1:0] FIRST_HIGH = CW'(TCK_DIV);
    localparam logic [CW-1:0] LAST_HIGH  = CW'(2 * TCK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Phase counter; held at the start of a low half whenever disabled or in reset.
    always_ff @(posedge clk) begin
        if (!reset_n || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST_HIGH) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tck  = (r_cnt >= FIRST_HIGH);
    assign o_rise = i_en && (r_cnt == LAST_LOW);
    assign o_fall = i_en && (r_cnt == LAST_HIGH);
endmodule

// File: rtl/cpu_debug_jtag_host.sv
// cpu_debug_jtag_host: on-chip JTAG host walking UIR/CDR/SDR/UDR on the
// virtual-JTAG side of the CPU debug slave and shifting one DR per command.
// Optional: define CPU_DEBUG_JTAG_HOST_IR_CACHE_EN to skip UIR when the IR is unchanged.
module cpu_debug_jtag_host
    import cpu_debug_jtag_pkg::*;
#(
    parameter int DR_WIDTH = DEF_DR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int TCK_DIV  = DEF_TCK_DIV
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_debug_jtag_host_if.slave bus,
    output logic                 vji_tck,
    output logic                 vji_tdi,
    output logic [IR_WIDTH-1:0]  vji_ir_in,
    output logic                 vji_uir,
    output logic                 vji_cdr,
    output logic                 vji_sdr,
    output logic                 vji_udr,
    output logic                 vji_rti,
    input  logic                 vji_tdo,
    input  logic [IR_WIDTH-1:0]  vji_ir_out
);
    localparam int            BW       = $clog2(DR_WIDTH) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    state_t              r_state;
    state_t              w_next;
    logic [DR_WIDTH-1:0] r_sr;
    logic [DR_WIDTH-1:0] r_rsp_dr;
    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] r_rsp_ir;
    logic [BW-1:0]       r_bit;
    logic                r_tdi;
    logic                w_en;
    logic                w_rise;
    logic                w_fall;
    logic                w_accept;
    logic                w_skip_uir;

    assign w_en     = (r_state != ST_IDLE) && (r_state != ST_RESP);
    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;

    cpu_debug_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_en),
        .o_tck   (vji_tck),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

`ifdef CPU_DEBUG_JTAG_HOST_IR_CACHE_EN
    logic r_ir_loaded;

    // Remember that the slave holds r_ir once a UIR has actually completed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ir_loaded <= 1'b0;
        end else if (r_state == ST_UIR && w_fall) begin
            r_ir_loaded <= 1'b1;
        end
    end

    assign w_skip_uir = r_ir_loaded && (bus.cmd_ir == r_ir);
`else
    assign w_skip_uir = 1'b0;
`endif

    // State register; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: virtual-state changes happen only at the end of a TCK high half.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.cmd_valid) w_next = w_skip_uir ? ST_CDR : ST_UIR;
            ST_UIR:  if (w_fall) w_next = ST_CDR;
            ST_CDR:  if (w_fall) w_next = ST_SDR;
            ST_SDR:  if (w_fall && r_bit == BIT_LAST) w_next = ST_UDR;
            ST_UDR:  if (w_fall) w_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: one virtual-state flag at a time.
    always_comb begin
        vji_uir       = 1'b0;
        vji_cdr       = 1'b0;
        vji_sdr       = 1'b0;
        vji_udr       = 1'b0;
        vji_rti       = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                vji_rti       = 1'b1;
                bus.cmd_ready = 1'b1;
            end
            ST_UIR:  vji_uir = 1'b1;
            ST_CDR:  vji_cdr = 1'b1;
            ST_SDR:  vji_sdr = 1'b1;
            ST_UDR:  vji_udr = 1'b1;
            ST_RESP: begin
                vji_rti       = 1'b1;
                bus.rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: latch command, shift on TCK rise, update TDI and bit count at period end.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sr     <= '0;
            r_ir     <= '0;
            r_rsp_dr <= '0;
            r_rsp_ir <= '0;
            r_bit    <= '0;
            r_tdi    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sr <= bus.cmd_dr;
                r_ir <= bus.cmd_ir;
            end
            if (r_state == ST_SDR && w_rise) begin
                r_sr <= {vji_tdo, r_sr[DR_WIDTH-1:1]};
            end
            if (r_state == ST_CDR && w_rise) begin
                r_rsp_ir <= vji_ir_out;
            end
            if (w_fall) begin
                // TDI is presented for the whole low half that follows.
                r_tdi <= (w_next == ST_SDR) ? r_sr[0] : 1'b0;
                r_bit <= (r_state == ST_SDR) ? r_bit + BW'(1) : '0;
            end
            if (r_state == ST_UDR && w_fall) begin
                r_rsp_dr <= r_sr;
            end
        end
    end

    assign vji_tdi        = r_tdi;
    assign vji_ir_in      = r_ir;
    assign bus.rsp_dr     = r_rsp_dr;
    assign bus.rsp_ir_out = r_rsp_ir;
endmodule

// File: tb/tb_cpu_debug_jtag_host.sv
// Self-checking bench for cpu_debug_jtag_host with a loopback/tied TDO slave model.
module tb_cpu_debug_jtag_host;
    import cpu_debug_jtag_pkg::*;

    localparam int DRW  = 38;
    localparam int IRW  = 2;
    localparam int TDIV = 2;
    localparam int PER  = 2 * TDIV;
`ifdef CPU_DEBUG_JTAG_HOST_IR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    // {tck, tdi, uir, cdr, sdr, udr, rti, cmd_ready, rsp_valid, ir_in[1:0], rsp_ir_out[1:0], 3'b0}
    localparam logic [15:0] RST_PINS = {2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000};

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic [IRW-1:0] vji_ir_in;
    logic [IRW-1:0] vji_ir_out = '0;
    logic           vji_tdo;
    logic           r_slv = 1'b0;
    int             tdo_mode = 0;
    int             n_vec = 0;
    int             n_mis = 0;
    bit             cache_ok = 1'b0;
    logic [IRW-1:0] cache_ir = '0;

    cpu_debug_jtag_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus ();

    cpu_debug_jtag_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(TDIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .vji_tck    (vji_tck),
        .vji_tdi    (vji_tdi),
        .vji_ir_in  (vji_ir_in),
        .vji_uir    (vji_uir),
        .vji_cdr    (vji_cdr),
        .vji_sdr    (vji_sdr),
        .vji_udr    (vji_udr),
        .vji_rti    (vji_rti),
        .vji_tdo    (vji_tdo),
        .vji_ir_out (vji_ir_out)
    );

    always #5 clk = ~clk;

    // Slave model: TDO returns the TDI seen one TCK earlier (mode 0), or is tied 1/0.
    always @(posedge vji_tck) r_slv <= vji_tdi;
    assign vji_tdo = (tdo_mode == 0) ? r_slv : (tdo_mode == 1);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pins();
        return {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
                bus.cmd_ready, bus.rsp_valid, vji_ir_in, bus.rsp_ir_out, 3'b000};
    endfunction

    function automatic logic [DRW-1:0] rand_dr();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DRW-1:0];
    endfunction

    // One full command; called just after a negedge with the host idle.
    task automatic run_cmd(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr, input int mode,
                           input logic [IRW-1:0] irout, input int hold);
        int lat, nu, nc, ns, nd, bad_hot, bad_ord, bad_ir, f, last_f, exp_lat;
        bit skip;
        logic [DRW-1:0] exp_dr;
        lat = 1; nu = 0; nc = 0; ns = 0; nd = 0;
        bad_hot = 0; bad_ord = 0; bad_ir = 0; last_f = 0;
        skip    = CACHE && cache_ok && (ir == cache_ir);
        exp_lat = (skip ? DRW + 2 : DRW + 3) * PER + 1;
        case (mode)
            0:       exp_dr = {dr[DRW-2:0], 1'b0};
            1:       exp_dr = '1;
            default: exp_dr = '0;
        endcase
        tdo_mode   = mode;
        vji_ir_out = irout;
        chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = ir;
        bus.cmd_dr    = dr;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        bus.cmd_dr = ~dr;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid || lat > 400) break;
            nu += int'(vji_uir);
            nc += int'(vji_cdr);
            ns += int'(vji_sdr);
            nd += int'(vji_udr);
            if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) != 1) bad_hot++;
            f = vji_uir ? 1 : vji_cdr ? 2 : vji_sdr ? 3 : vji_udr ? 4 : 0;
            if (f < last_f) bad_ord++;
            last_f = f;
            if (f != 0 && vji_ir_in !== ir) bad_ir++;
            @(posedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_dr", 64'(bus.rsp_dr), 64'(exp_dr));
        chk("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(irout));
        chk("uir_cycles", 64'(nu), skip ? 64'd0 : 64'(PER));
        chk("cdr_cycles", 64'(nc), 64'(PER));
        chk("sdr_cycles", 64'(ns), 64'(DRW * PER));
        chk("udr_cycles", 64'(nd), 64'(PER));
        chk("flag_onehot", 64'(bad_hot), 64'd0);
        chk("flag_order", 64'(bad_ord), 64'd0);
        chk("ir_in_hold", 64'(bad_ir), 64'd0);
        if (!skip) begin
            cache_ok = 1'b1;
            cache_ir = ir;
        end
        if (hold > 0) bus.cmd_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1 bus.cmd_valid = 1'b0;
            @(negedge clk);
            chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_released", 64'(bus.rsp_valid), 64'd0);
        chk("cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
        chk("rti_idle", 64'(vji_rti), 64'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_ir    = '0;
        bus.cmd_dr    = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_pins", 64'(pins()), 64'(RST_PINS));
        chk("reset_rsp_dr", 64'(bus.rsp_dr), 64'd0);

        run_cmd(IR_BREAK, 38'h15_5555_5555, 0, 2'b10, 0);
        run_cmd(IR_OCIMEM, rand_dr(), 1, 2'b01, 0);
        run_cmd(IR_TRACEMEM, rand_dr(), 2, 2'b11, 10);
        run_cmd(IR_TRACECTRL, rand_dr(), 0, 2'b10, 0);

        // Reset in the middle of a transfer (cycle 60 is inside SDR, TCK high).
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = IR_BREAK;
        bus.cmd_dr    = rand_dr();
        vji_ir_out    = 2'b01;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (59) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_pins", 64'(pins()), 64'(RST_PINS));
        chk("midreset_rsp_dr", 64'(bus.rsp_dr), 64'd0);
        reset_n  = 1'b1;
        cache_ok = 1'b0;
        repeat (200) @(negedge clk);
        chk("dropped_no_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("dropped_tck_low", 64'(vji_tck), 64'd0);

        run_cmd(IR_OCIMEM, rand_dr(), 0, 2'b11, 1);
        run_cmd(IR_TRACEMEM, rand_dr(), 0, 2'b01, 0);
        run_cmd(IR_TRACEMEM, rand_dr(), 1, 2'b10, 0);
        run_cmd(IR_TRACECTRL, rand_dr(), 2, 2'b00, 0);

        for (int k = 0; k < 8; k++) begin
            run_cmd(IRW'($urandom_range(0, 3)), rand_dr(), int'($urandom_range(0, 2)),
                    IRW'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/cpu_debug_jtag_host.md
# cpu_debug_jtag_host

Clock-domain-local JTAG host that drives the virtual-JTAG side of the CPU debug slave: it generates TCK, walks the virtual-state sequence (UIR, CDR, SDR, UDR) and shifts a 38-bit DR through TDI while capturing TDO. It sits between an on-chip debug command source (test sequencer or debug bridge) and the debug slave's TCK-domain logic. It is the initiator end of that interface, replacing the vendor JTAG PHY where an on-chip master is needed.

## Interface
Parameters:
- DR_WIDTH, 38, shift-register length; must be ≥ 2.
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 2, clk cycles per TCK half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with no pending response.
- cmd_ir  in  IR_WIDTH  IR code: 0 ocimem, 1 tracemem, 2 break, 3 tracectrl.
- cmd_dr  in  DR_WIDTH  data shifted out, LSB first.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response accept.
- rsp_dr  out  DR_WIDTH  captured TDO stream; bit 0 = first bit shifted.
- rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled in CDR.
- vji_tck, vji_tdi  out  1  JTAG clock/data to slave.
- vji_ir_in  out  IR_WIDTH  current IR to slave.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1  virtual-state flags.
- vji_tdo  in  1  slave data out.
- vji_ir_out  in  IR_WIDTH  slave IR status.

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RESP. One TCK period = 2·TCK_DIV clk cycles: low half then high half.
- Accept on cmd_valid && cmd_ready: latch cmd_dr into sr, cmd_ir into ir_reg; enter UIR.
- UIR: 1 TCK period; vji_uir=1, vji_ir_in=ir_reg (vji_ir_in updates at UIR entry and holds afterwards).
- CDR: 1 TCK period; vji_cdr=1; rsp_ir_out captured on the TCK-rise strobe.
- SDR: exactly DR_WIDTH TCK periods; vji_sdr=1; vji_tdi=sr[0]; on each TCK-rise strobe sr <= {vji_tdo, sr[DR_WIDTH-1:1]}.
- UDR: 1 TCK period; vji_udr=1; then RESP with rsp_dr=sr.
- RESP: rsp_valid=1 until rsp_ready; then IDLE.
- vji_rti=1 only in IDLE and RESP. At most one virtual-state flag is high at any time.
- State flags and vji_tdi change only on the clk cycle the TCK low half begins. Transitions occur at the end of a TCK high half.
- cmd_valid in non-IDLE states is ignored; no queuing.

## Timing
- Reset values: vji_tck 0, vji_tdi 0, all flags 0 except vji_rti 1, vji_ir_in 0, cmd_ready 1, rsp_valid 0, rsp_dr 0, rsp_ir_out 0, sr 0.
- The accept cycle is cycle 0. UIR begins at cycle 1 with TCK low.
- rsp_valid rises (DR_WIDTH+3)·2·TCK_DIV + 1 cycles after accept. Defaults give 165.
- Reset asserted mid-operation: next cycle all reset values apply, TCK is forced low without completing the period, and the command is dropped with no response.
- rsp_ready held high in RESP: return to IDLE on that cycle. cmd_ready rises the following cycle.

## Configuration
- CPU_DEBUG_JTAG_HOST_IR_CACHE_EN defined: if cmd_ir equals the last IR loaded and at least one UIR has completed since reset, skip UIR and go straight to CDR. Latency becomes (DR_WIDTH+2)·2·TCK_DIV + 1.
- Undefined: UIR is always executed.

## Structure
- Package cpu_debug_jtag_pkg: state enum; IR code constants (IR_OCIMEM, IR_TRACEMEM, IR_BREAK, IR_TRACECTRL); default DR_WIDTH/IR_WIDTH constants.
- Sub-module cpu_debug_jtag_tck_gen: divider producing vji_tck plus single-cycle tck_rise/tck_fall strobes. Enabled outside IDLE/RESP; resets to TCK low.

## Test plan
- Defaults, cmd_ir=2, cmd_dr=38'h15_5555_5555, slave loopback (tdo=tdi delayed one TCK) → rsp_valid at cycle 165. The UIR/CDR/SDR/UDR flags appear in order; SDR is high for exactly 38 TCK periods.
- vji_tdo tied 1 → rsp_dr=38'h3F_FFFF_FFFF. vji_tdo tied 0 → rsp_dr=0.
- vji_ir_out=2'b10 during CDR → rsp_ir_out=2'b10. vji_ir_in=2 from UIR onward.
- rsp_ready held low 10 cycles → rsp_valid stays high and cmd_ready low; a cmd_valid pulse in this window is not accepted.
- reset_n low at cycle 60 of a transfer → next cycle all outputs at reset values; a new command then completes normally.
- With CPU_DEBUG_JTAG_HOST_IR_CACHE_EN, two back-to-back commands with ir=1 → first latency 165, second 161 with no vji_uir pulse. A third command with ir=3 → 165.
